// File: rtl/counter_gated_bank.sv
// counter_gated_bank: gated multi-channel event counter bank with start/abort handshake and registered readout
module counter_gated_bank #(
    parameter int WIDTH = 32,
    parameter int N_CH = 4,
    parameter int GATE_W = 24,
    parameter bit SATURATE = 1'b0,
    parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [N_CH-1:0]   inc,
    output logic              busy,
    output logic              done,
    output logic [N_CH-1:0]   ovf,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_ovf
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [GATE_W-1:0] timer;
    logic [WIDTH-1:0] cnt [N_CH];
    logic sel_ok;
    assign sel_ok = 32'(rd_sel) < 32'(N_CH);
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            ovf     <= '0;
            rd_data <= '0;
            rd_ovf  <= 1'b0;
            for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
        end else begin
            rd_data <= sel_ok ? cnt[rd_sel] : '0;
            rd_ovf  <= sel_ok & ovf[rd_sel];
            if (state == IDLE) begin
                if (start) begin
                    timer <= gate_cycles;
                    state <= (gate_cycles == '0) ? DONE : RUN;
                    ovf   <= '0;
                    for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
                end
            end else if (state == RUN) begin
                timer <= timer - GATE_W'(1);
                // abort wins over the natural end of the window
                state <= abort ? IDLE : (timer == GATE_W'(1)) ? DONE : RUN;
                for (int i = 0; i < N_CH; i++) begin
                    if (inc[i]) begin
                        if (&cnt[i]) begin
                            ovf[i] <= 1'b1;
                            cnt[i] <= SATURATE ? cnt[i] : '0;
                        end else begin
                            cnt[i] <= cnt[i] + WIDTH'(1);
                        end
                    end
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_counter_gated_bank.sv
// tb_counter_gated_bank: wrap (4 ch) and saturate (3 ch) banks driven in parallel, checked against a cycle model and vector table
module tb_counter_gated_bank;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [9:0] gate = '0;
    logic [3:0] inc = '0;
    logic [1:0] rd_sel = '0;
    logic busy_a, done_a, rd_ovf_a, busy_b, done_b, rd_ovf_b;
    logic [3:0] ovf_a;
    logic [2:0] ovf_b;
    logic [7:0] rd_a, rd_b;
    int errors = 0, checks = 0;
    bit chk_en = 1'b0;
    always #5 clk = ~clk;

    counter_gated_bank #(.WIDTH(8), .N_CH(4), .GATE_W(10), .SATURATE(1'b0)) dut_a (
        .CLK(clk), .reset(reset), .start(start), .abort(abort), .gate_cycles(gate),
        .inc(inc), .busy(busy_a), .done(done_a), .ovf(ovf_a), .rd_sel(rd_sel),
        .rd_data(rd_a), .rd_ovf(rd_ovf_a));
    counter_gated_bank #(.WIDTH(8), .N_CH(3), .GATE_W(10), .SATURATE(1'b1)) dut_b (
        .CLK(clk), .reset(reset), .start(start), .abort(abort), .gate_cycles(gate),
        .inc(inc[2:0]), .busy(busy_b), .done(done_b), .ovf(ovf_b), .rd_sel(rd_sel),
        .rd_data(rd_b), .rd_ovf(rd_ovf_b));

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: remaining window length, done pulse, counts as plain integers
    int mcnt [2][4];
    bit movf [2][4];
    int mleft [2];
    bit mdone [2];
    int mrd [2];
    bit mrdo [2];
    function automatic int nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction
    function automatic logic [3:0] povf(input int m);
        logic [3:0] v = '0;
        for (int c = 0; c < 4; c++) v[c] = movf[m][c];
        return v;
    endfunction
    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int c = 0; c < 4; c++) begin mcnt[m][c] = 0; movf[m][c] = 0; end
                mleft[m] = 0; mdone[m] = 0; mrd[m] = 0; mrdo[m] = 0;
            end else begin
                mrd[m] = (int'(rd_sel) < nch(m)) ? mcnt[m][rd_sel] : 0;
                mrdo[m] = (int'(rd_sel) < nch(m)) ? movf[m][rd_sel] : 1'b0;
                if (mleft[m] > 0) begin
                    for (int c = 0; c < nch(m); c++)
                        if (inc[c]) begin
                            if (mcnt[m][c] == 255) movf[m][c] = 1;
                            mcnt[m][c] = (m == 1) ? ((mcnt[m][c] + 1 > 255) ? 255 : mcnt[m][c] + 1)
                                                  : (mcnt[m][c] + 1) % 256;
                        end
                    mleft[m] = abort ? 0 : mleft[m] - 1;
                    mdone[m] = !abort && mleft[m] == 0;
                end else if (mdone[m]) begin
                    mdone[m] = 0;
                end else if (start) begin
                    for (int c = 0; c < 4; c++) begin mcnt[m][c] = 0; movf[m][c] = 0; end
                    mleft[m] = int'(gate);
                    mdone[m] = gate == 0;
                end
            end
        end
    end
    always @(negedge clk) if (chk_en) begin
        chk("model busy_a", busy_a, mleft[0] > 0);
        chk("model done_a", done_a, mdone[0]);
        chk("model rd_a", rd_a, mrd[0]);
        chk("model rd_ovf_a", rd_ovf_a, mrdo[0]);
        chk("model ovf_a", ovf_a, povf(0));
        chk("model busy_b", busy_b, mleft[1] > 0);
        chk("model done_b", done_b, mdone[1]);
        chk("model rd_b", rd_b, mrd[1]);
        chk("model rd_ovf_b", rd_ovf_b, mrdo[1]);
        chk("model ovf_b", ovf_b, povf(1) & 4'b0111);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sweep(input logic [3:0][7:0] ea, input logic [3:0] eao,
                         input logic [3:0][7:0] eb, input logic [3:0] ebo);
        chk("ovf_a", ovf_a, eao);
        chk("ovf_b", ovf_b, ebo[2:0]);
        for (int s = 0; s < 4; s++) begin
            rd_sel = s[1:0];
            tick;
            chk("rd_a", rd_a, ea[s]);
            chk("rd_ovf_a", rd_ovf_a, eao[s]);
            chk("rd_b", rd_b, eb[s]);
            chk("rd_ovf_b", rd_ovf_b, ebo[s]);
        end
    endtask

    task automatic run_window(input logic [9:0] g, input logic [3:0] incv);
        start = 1; gate = g; inc = incv;
        tick;
        start = 0;
        for (int j = 0; j < int'(g); j++) begin
            chk("win busy_a", busy_a, 1); chk("win busy_b", busy_b, 1); chk("win done_a", done_a, 0);
            tick;
        end
        inc = '0;
        chk("end busy_a", busy_a, 0); chk("end done_a", done_a, 1); chk("end done_b", done_b, 1);
        tick;
        chk("post done_a", done_a, 0); chk("post busy_a", busy_a, 0);
    endtask

    typedef struct packed {
        logic [9:0] g;
        logic [3:0] incv;
        logic [3:0][7:0] a;
        logic [3:0] ao;
        logic [3:0][7:0] b;
        logic [3:0] bo;
    } vec_t;
    vec_t vecs [6];

    initial begin
        vecs[0] = '{10'd10,  4'b0001, {8'd0, 8'd0, 8'd0, 8'd10},    4'b0000, {8'd0, 8'd0, 8'd0, 8'd10},     4'b0000};
        vecs[1] = '{10'd300, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd44},    4'b0001, {8'd0, 8'd0, 8'd0, 8'd255},    4'b0001};
        vecs[2] = '{10'd0,   4'b1111, {8'd0, 8'd0, 8'd0, 8'd0},     4'b0000, {8'd0, 8'd0, 8'd0, 8'd0},      4'b0000};
        vecs[3] = '{10'd256, 4'b0110, {8'd0, 8'd0, 8'd0, 8'd0},     4'b0110, {8'd0, 8'd255, 8'd255, 8'd0},  4'b0110};
        vecs[4] = '{10'd255, 4'b1001, {8'd255, 8'd0, 8'd0, 8'd255}, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd255},    4'b0000};
        vecs[5] = '{10'd7,   4'b1111, {8'd7, 8'd7, 8'd7, 8'd7},     4'b0000, {8'd0, 8'd7, 8'd7, 8'd7},      4'b0000};
        tick; tick;
        reset = 0;
        chk_en = 1;
        chk("reset busy_a", busy_a, 0); chk("reset done_a", done_a, 0);
        chk("reset rd_a", rd_a, 0); chk("reset ovf_a", ovf_a, 0);
        // normal window with mixed strobe patterns
        start = 1; gate = 10; inc = '0;
        tick;
        start = 0;
        for (int j = 1; j <= 10; j++) begin
            inc = {j == 5, 1'b0, j % 2 == 1, 1'b1};
            chk("t1 busy_a", busy_a, 1);
            tick;
        end
        inc = '0;
        chk("t1 busy_a end", busy_a, 0); chk("t1 done_a", done_a, 1);
        tick;
        chk("t1 done_a once", done_a, 0);
        sweep({8'd1, 8'd0, 8'd5, 8'd10}, 4'b0, {8'd0, 8'd0, 8'd5, 8'd10}, 4'b0);
        for (int v = 0; v < 6; v++) begin
            run_window(vecs[v].g, vecs[v].incv);
            sweep(vecs[v].a, vecs[v].ao, vecs[v].b, vecs[v].bo);
        end
        // abort in RUN cycle 3 keeps partial count and produces no done
        start = 1; gate = 10; inc = 4'b0001;
        tick;
        start = 0;
        tick; tick;
        abort = 1;
        tick;
        abort = 0; inc = '0;
        chk("abort busy_a", busy_a, 0); chk("abort done_a", done_a, 0);
        for (int j = 0; j < 3; j++) begin tick; chk("abort no done", done_a, 0); end
        sweep({8'd0, 8'd0, 8'd0, 8'd3}, 4'b0, {8'd0, 8'd0, 8'd0, 8'd3}, 4'b0);
        // start held through RUN and DONE is only re-accepted back in IDLE
        start = 1; gate = 5;
        tick;
        for (int j = 0; j < 5; j++) begin chk("held busy", busy_a, 1); tick; end
        chk("held done", done_a, 1); chk("held busy done", busy_a, 0);
        tick;
        chk("held idle busy", busy_a, 0); chk("held idle done", done_a, 0);
        tick;
        chk("held restart busy", busy_a, 1);
        start = 0;
        repeat (5) tick;
        chk("held 2nd done", done_a, 1);
        tick;
        sweep('0, 4'b0, '0, 4'b0);
        // reset in the middle of a window
        start = 1; gate = 20; inc = 4'b1111;
        tick;
        start = 0;
        repeat (6) tick;
        reset = 1;
        tick;
        reset = 0; inc = '0;
        chk("rst busy_a", busy_a, 0); chk("rst done_a", done_a, 0);
        chk("rst ovf_a", ovf_a, 0); chk("rst rd_a", rd_a, 0);
        sweep('0, 4'b0, '0, 4'b0);
        run_window(10'd4, 4'b0001);
        sweep({8'd0, 8'd0, 8'd0, 8'd4}, 4'b0, {8'd0, 8'd0, 8'd0, 8'd4}, 4'b0);
        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom % 6) == 0;
            gate = (($urandom % 10) == 0) ? 10'($urandom_range(250, 600)) : 10'($urandom_range(0, 30));
            inc = 4'($urandom);
            abort = ($urandom % 64) == 0;
            rd_sel = 2'($urandom);
            reset = ($urandom % 500) == 0;
            tick;
        end
        reset = 0; start = 0; abort = 0; inc = '0;
        tick; tick;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
